t01_ai_feature_extract: RTL

Board feature extractor for the AI placement loop.
- Started by the AI game engine's extract_start level, raised while the engine evaluates a candidate placement.
- Scans the placed board (landed piece merged) one row per cycle and computes the heuristic features.
- Those features feed the AI scoring stage, whose completion returns to the engine as ofm_done.
- Sequential multi-cycle scanner: IDLE/SCAN/SUM/DONE FSM, per-column height tracking, accumulators, one-cycle done pulse.

---
 rtl/t01_ai_pkg.sv | 30 +++
 rtl/t01_popcount10.sv | 19 +
 rtl/t01_ai_feature_extract.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/t01_ai_pkg.sv
// Shared constants, widths, FSM state codes and helpers for the AI board feature extractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package t01_ai_pkg;

    // Board geometry: row 0 is the top row, bit c of a row word is column c.
    localparam int ROWS    = 20;
    localparam int COLS    = 10;
    localparam int RA_W    = 5;

    // Feature and internal widths, sized for the full-board worst case.
    localparam int LINES_W = 5;
    localparam int FEAT_W  = 8;
    localparam int H_W     = 5;
    localparam int COL_W   = 4;

    // Scanner FSM state codes.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_SUM  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef logic [H_W-1:0] height_t;

    // Unsigned absolute difference of two column heights.
    function automatic height_t abs_diff(input height_t a, input height_t b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/t01_popcount10.sv
// Combinational population count of a board row word (COLS bits, 4-bit result).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
module t01_popcount10
    import t01_ai_pkg::*;
(
    input  logic [COLS-1:0] vec,
    output logic [3:0]      cnt
);

    // Add up the set bits one column at a time.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < COLS; i++) begin
            cnt = cnt + {3'b000, vec[i]};
        end
    end

endmodule

// File: rtl/t01_ai_feature_extract.sv
// Scans the placed board one row per cycle and produces lines/holes/height/bumpiness features.
// Latency: start edge to extract_done pulse is ROWS+COLS+1 cycles (31 at defaults).
// Backpressure: none; start edges are ignored unless IDLE and a held start never retriggers.
module t01_ai_feature_extract
    import t01_ai_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                extract_start,
    output logic [RA_W-1:0]     row_addr,
    input  logic [COLS-1:0]     row_data,
    output logic [LINES_W-1:0]  lines_full,
    output logic [FEAT_W-1:0]   holes,
    output logic [FEAT_W-1:0]   height_sum,
    output logic [FEAT_W-1:0]   bumpiness,
    output logic                busy,
    output logic                extract_done
);

    logic [1:0]       state;
    logic             start_q;
    height_t          h [COLS];
    logic [COLS-1:0]  seen;
    logic [COL_W-1:0] col;

    logic             start_edge;
    logic             last_row;
    logic             last_col;
    logic [COLS-1:0]  hole_vec;
    logic [3:0]       hole_inc;
    height_t          h_cur;
    height_t          h_nxt;
    height_t          bump_inc;

    // Only a fresh rising edge seen while idle starts a scan.
    assign start_edge   = extract_start & ~start_q & (state == ST_IDLE);
    assign last_row     = (row_addr == RA_W'(ROWS - 1));
    assign last_col     = (col == COL_W'(COLS - 1));

    // A cell is a hole if it is empty and its column was already topped by an earlier row.
    assign hole_vec     = seen & ~row_data;

    assign busy         = (state == ST_SCAN) || (state == ST_SUM);
    assign extract_done = (state == ST_DONE);

    t01_popcount10 u_hole_cnt (
        .vec (hole_vec),
        .cnt (hole_inc)
    );

    // Select the current and right-hand neighbour heights for the column sweep.
    always_comb begin
        h_cur = h[col];
        h_nxt = '0;
        if (!last_col) begin
            h_nxt = h[col + COL_W'(1)];
        end
        bump_inc = abs_diff(h_cur, h_nxt);
    end

    // Delay the request level by one cycle for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= 1'b0;
        end else begin
            start_q <= extract_start;
        end
    end

    // Sequencing: row walk in SCAN, column walk in SUM, single DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            row_addr <= '0;
            col      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        state    <= ST_SCAN;
                        row_addr <= '0;
                        col      <= '0;
                    end
                end
                ST_SCAN: begin
                    if (last_row) begin
                        row_addr <= '0;
                        col      <= '0;
                        state    <= ST_SUM;
                    end else begin
                        row_addr <= row_addr + RA_W'(1);
                    end
                end
                ST_SUM: begin
                    if (last_col) begin
                        state <= ST_DONE;
                    end else begin
                        col <= col + COL_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Column heights: the first filled cell met from the top fixes the height of its column.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < COLS; c++) begin
                h[c] <= '0;
            end
            seen <= '0;
        end else if (start_edge) begin
            for (int c = 0; c < COLS; c++) begin
                h[c] <= '0;
            end
            seen <= '0;
        end else if (state == ST_SCAN) begin
            for (int c = 0; c < COLS; c++) begin
                if (row_data[c] && !seen[c]) begin
                    h[c] <= H_W'(ROWS) - H_W'(row_addr);
                end
            end
            seen <= seen | row_data;
        end
    end

    // Feature accumulators: cleared on an accepted start, held after the sweep completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lines_full <= '0;
            holes      <= '0;
            height_sum <= '0;
            bumpiness  <= '0;
        end else if (start_edge) begin
            lines_full <= '0;
            holes      <= '0;
            height_sum <= '0;
            bumpiness  <= '0;
        end else if (state == ST_SCAN) begin
            holes <= holes + FEAT_W'(hole_inc);
            if (&row_data) begin
                lines_full <= lines_full + LINES_W'(1);
            end
        end else if (state == ST_SUM) begin
            height_sum <= height_sum + FEAT_W'(h_cur);
            if (!last_col) begin
                bumpiness <= bumpiness + FEAT_W'(bump_inc);
            end
        end
    end

endmodule
